j1_io_bridge: RTL and testbench
===============================

J1_IO_BRIDGE -- requirements
Module: j1_io_bridge

Interface
REQ-001 Parameter NSLV, default 4, number of peripheral slots (1..8).
REQ-002 Parameter PAGE_BASE, default 8'h67; slot i decodes at address page io_addr[15:8] = PAGE_BASE+i.
REQ-003 Parameter STAT_PAGE, default 8'hFF; bridge-internal status page.
REQ-004 Parameter TMO_CYC, default 15, slave acknowledge timeout in cycles (2..255).
REQ-005 Parameter DFLT_DATA, default 16'h0666, read data returned on unmapped or timed-out access.
REQ-006 Ports, one clock domain; reset is synchronous and active-high:
- sys_clk_i  in  1  system clock
- sys_rst_i  in  1  synchronous active-high reset
- io_rd  in  1  CPU read strobe
- io_wr  in  1  CPU write strobe
- io_addr  in  16  CPU IO address
- io_dout  in  16  CPU write data
- io_din  out  16  read data to CPU
- io_ack  out  1  one-cycle completion pulse
- io_busy  out  1  transaction in flight
- slv_cs  out  NSLV  one-hot chip select
- slv_rd  out  1  slave read strobe
- slv_wr  out  1  slave write strobe
- slv_addr  out  4  latched io_addr[3:0]
- slv_wdata  out  16  latched write data
- slv_rdata  in  16*NSLV  slot i read data at bits [16i+15:16i]
- slv_ack  in  NSLV  slave completion, one bit per slot

Function
REQ-007 FSM states IDLE, XFER, RESP; only IDLE accepts requests.
REQ-008 IDLE, cycle T, io_rd or io_wr high: latch io_addr, io_dout, decoded slot index; io_wr and io_rd both high -> write only, rd ignored.
REQ-009 Mapped slot: T+1 enter XFER; slv_cs[idx] high from T+1 through the ack cycle inclusive; slv_rd/slv_wr high for cycle T+1 only.
REQ-010 XFER samples slv_ack[idx] from T+1 onward; ack at cycle A -> RESP at A+1 with io_ack=1, io_din=slv_rdata slot idx (reads) or DFLT_DATA (writes), registered.
REQ-011 Acks from non-selected slots ignored.
REQ-012 Timeout counter starts at 1 in cycle T+1; no ack by count TMO_CYC -> RESP, io_din=DFLT_DATA, status bit TMO set, ERR_ADDR=latched address.
REQ-013 Unmapped page (outside slot range, not STAT_PAGE): no cs asserted, RESP at T+1 with DFLT_DATA, status bit UNMAP set, ERR_ADDR loaded.
REQ-014 STAT_PAGE: handled internally, RESP at T+1; read offset 0 = {13'b0, OVR, UNMAP, TMO}, 1 = ERR_ADDR, 2 = STATS (REQ-020), others = 16'h0000; write offset 0 clears each flag whose io_dout bit is 1 (W1C).
REQ-015 RESP lasts exactly one cycle, then IDLE; io_ack low in all other states; io_din holds last value otherwise.
REQ-016 io_busy high in XFER and RESP.
REQ-017 io_rd/io_wr high while not IDLE: request dropped, no slave strobe, OVR set.
REQ-018 Hardware flag set and W1C clear in same cycle: set wins.

Reset
REQ-019 sys_rst_i high at any rising edge, including mid-transaction: state IDLE, slv_cs=0, slv_rd=slv_wr=0, io_ack=0, io_busy=0, io_din=16'h0000, slv_addr=0, slv_wdata=0, flags=0, ERR_ADDR=0, counter=0; in-flight transaction abandoned with no ack.

Configuration
REQ-020 Macro J1_IO_BRIDGE_STATS_EN defined: 16-bit counter increments on every RESP cycle, saturates at 16'hFFFF, readable at STAT_PAGE offset 2, cleared by any write to offset 2; undefined: no counter, offset 2 reads 16'h0000, writes to it ignored.

Verification
REQ-021 Read 16'h6803, slot 1 acks at T+2 with 16'h1234 -> slv_cs=4'b0010 T+1..T+2, slv_rd only at T+1, io_ack and io_din=16'h1234 at T+3.
REQ-022 Write 16'h6A01 data 16'hBEEF, slot 3 never acks, TMO_CYC=15 -> io_ack at T+16 with 16'h0666; read 16'hFF00 -> 16'h0001; read 16'hFF01 -> 16'h6A01.
REQ-023 Read 16'h5000 -> no cs, io_ack at T+1 with 16'h0666, UNMAP set; write 16'hFF00 data 16'h0002 -> UNMAP cleared.
REQ-024 io_rd pulse at T+1 during slot 0 transaction -> dropped, no second strobe, OVR=1 at 16'hFF00.
REQ-025 sys_rst_i at T+2 of stalled transaction -> next cycle slv_cs=0, io_busy=0, no io_ack; new read 16'h6700 completes normally.
REQ-026 With J1_IO_BRIDGE_STATS_EN: three completed accesses, then read 16'hFF02 -> 16'h0003; without macro -> 16'h0000.

Source files
------------

// File: rtl/j1_io_bridge_if.sv
// Bus bundle between the J1 CPU IO port, the bridge and its peripheral slots.
// master: the CPU/peripheral side that drives requests and slave responses.
// slave:  the bridge, which accepts CPU requests and drives the slot strobes.
interface j1_io_bridge_if #(
  parameter int NSLV = 4
);
  logic                   io_rd;
  logic                   io_wr;
  logic [15:0]            io_addr;
  logic [15:0]            io_dout;
  logic [15:0]            io_din;
  logic                   io_ack;
  logic                   io_busy;
  logic [NSLV-1:0]        slv_cs;
  logic                   slv_rd;
  logic                   slv_wr;
  logic [3:0]             slv_addr;
  logic [15:0]            slv_wdata;
  logic [16*NSLV-1:0]     slv_rdata;
  logic [NSLV-1:0]        slv_ack;

  modport master (
    output io_rd, io_wr, io_addr, io_dout, slv_rdata, slv_ack,
    input  io_din, io_ack, io_busy, slv_cs, slv_rd, slv_wr, slv_addr, slv_wdata
  );

  modport slave (
    input  io_rd, io_wr, io_addr, io_dout, slv_rdata, slv_ack,
    output io_din, io_ack, io_busy, slv_cs, slv_rd, slv_wr, slv_addr, slv_wdata
  );
endinterface

// File: rtl/j1_io_bridge.sv
// J1 IO bridge: decodes CPU IO accesses onto NSLV peripheral slots, one page
// (256 addresses) per slot starting at PAGE_BASE, with a per-access ack
// timeout and a bridge-internal status page at STAT_PAGE.
// Optional feature: define J1_IO_BRIDGE_STATS_EN to add a saturating
// completed-access counter readable at status offset 2.
//
// state | meaning
// IDLE  | waiting for a CPU request; the only state that accepts one
// XFER  | slot selected, waiting for its ack or the timeout
// RESP  | one-cycle completion: io_ack high, io_din valid
//
// Status page: offset 0 = {13'b0, OVR, UNMAP, TMO} (write 1 to clear),
// offset 1 = address of the last unmapped or timed-out access,
// offset 2 = access counter (zero when the counter is not built).
// Writes to the status page complete with io_din = DFLT_DATA, like any write.
module j1_io_bridge #(
  parameter int          NSLV      = 4,
  parameter logic [7:0]  PAGE_BASE = 8'h67,
  parameter logic [7:0]  STAT_PAGE = 8'hFF,
  parameter int          TMO_CYC   = 15,
  parameter logic [15:0] DFLT_DATA = 16'h0666
) (
  input  logic           sys_clk_i,
  input  logic           sys_rst_i,
  j1_io_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  localparam logic [8:0] BASE_EXT  = {1'b0, PAGE_BASE};
  localparam logic [8:0] LIMIT_EXT = BASE_EXT + 9'(NSLV);
  localparam logic [7:0] TMO_LAST  = 8'(TMO_CYC);

  localparam int FLG_TMO   = 0;
  localparam int FLG_UNMAP = 1;
  localparam int FLG_OVR   = 2;

  state_t          state_q, state_d;
  logic [NSLV-1:0] cs_q, cs_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            ack_q, ack_d;
  logic [15:0]     din_q, din_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [2:0]      idx_q, idx_d;
  logic            wr_op_q, wr_op_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [2:0]      flags_q, flags_d;
  logic [2:0]      flag_set, flag_clr;
  logic [15:0]     err_q, err_d;
  logic [15:0]     stats_q;
`ifdef J1_IO_BRIDGE_STATS_EN
  logic            stats_clr;
`endif

  logic            req;
  logic            is_stat;
  logic            in_range;
  logic [2:0]      idx_dec;
  logic [NSLV-1:0] cs_dec;
  logic            ack_sel;
  logic [15:0]     rdata_sel;
  logic [15:0]     stat_rdata;

  // Request decode: page classification, slot index and one-hot select.
  always_comb begin
    req      = bus.io_rd | bus.io_wr;
    is_stat  = (bus.io_addr[15:8] == STAT_PAGE);
    in_range = ({1'b0, bus.io_addr[15:8]} >= BASE_EXT) &&
               ({1'b0, bus.io_addr[15:8]} <  LIMIT_EXT);
    // Slot offset fits in 3 bits, so only the low page bits matter.
    idx_dec  = bus.io_addr[10:8] - PAGE_BASE[2:0];
    cs_dec   = '0;
    for (int i = 0; i < NSLV; i++) begin
      cs_dec[i] = (idx_dec == 3'(i));
    end
  end

  // Ack and read data of the slot latched for the current transaction.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = 16'h0000;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == 3'(i)) begin
        ack_sel   = bus.slv_ack[i];
        rdata_sel = bus.slv_rdata[16*i +: 16];
      end
    end
  end

  // Status page read mux, offset is the full low address byte.
  always_comb begin
    case (bus.io_addr[7:0])
      8'h00:   stat_rdata = {13'b0, flags_q};
      8'h01:   stat_rdata = err_q;
      8'h02:   stat_rdata = stats_q;
      default: stat_rdata = 16'h0000;
    endcase
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ack_d    = 1'b0;
    din_d    = din_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    wr_op_d  = wr_op_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    flag_set = 3'b000;
    flag_clr = 3'b000;
`ifdef J1_IO_BRIDGE_STATS_EN
    stats_clr = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus.io_addr;
          wdata_d = bus.io_dout;
          idx_d   = idx_dec;
          wr_op_d = bus.io_wr;
          if (is_stat) begin
            state_d = RESP;
            ack_d   = 1'b1;
            if (bus.io_wr) begin
              din_d = DFLT_DATA;
              if (bus.io_addr[7:0] == 8'h00) begin
                flag_clr = bus.io_dout[2:0];
              end
`ifdef J1_IO_BRIDGE_STATS_EN
              if (bus.io_addr[7:0] == 8'h02) begin
                stats_clr = 1'b1;
              end
`endif
            end else begin
              din_d = stat_rdata;
            end
          end else if (in_range) begin
            state_d = XFER;
            cs_d    = cs_dec;
            wr_d    = bus.io_wr;
            rd_d    = bus.io_rd & ~bus.io_wr;
            cnt_d   = 8'd1;
          end else begin
            state_d            = RESP;
            ack_d              = 1'b1;
            din_d              = DFLT_DATA;
            flag_set[FLG_UNMAP] = 1'b1;
            err_d              = bus.io_addr;
          end
        end
      end

      XFER: begin
        if (req) begin
          flag_set[FLG_OVR] = 1'b1;
        end
        if (ack_sel) begin
          state_d = RESP;
          ack_d   = 1'b1;
          cs_d    = '0;
          cnt_d   = 8'd0;
          din_d   = wr_op_q ? DFLT_DATA : rdata_sel;
        end else if (cnt_q == TMO_LAST) begin
          state_d           = RESP;
          ack_d             = 1'b1;
          cs_d              = '0;
          cnt_d             = 8'd0;
          din_d             = DFLT_DATA;
          flag_set[FLG_TMO] = 1'b1;
          err_d             = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      RESP: begin
        if (req) begin
          flag_set[FLG_OVR] = 1'b1;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cs_d    = '0;
      end
    endcase

    // A hardware set in the same cycle as a W1C clear keeps the flag set.
    flags_d = (flags_q & ~flag_clr) | flag_set;
  end

  // State register and registered outputs.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      cs_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      din_q   <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      idx_q   <= 3'd0;
      wr_op_q <= 1'b0;
      cnt_q   <= 8'd0;
      flags_q <= 3'b000;
      err_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      wr_op_q <= wr_op_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

`ifdef J1_IO_BRIDGE_STATS_EN
  // Saturating count of completion cycles; a write to offset 2 restarts it.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      stats_q <= 16'h0000;
    end else if (stats_clr) begin
      stats_q <= 16'h0000;
    end else if ((state_q == RESP) && (stats_q != 16'hFFFF)) begin
      stats_q <= stats_q + 16'd1;
    end
  end
`else
  assign stats_q = 16'h0000;
`endif

  assign bus.io_din    = din_q;
  assign bus.io_ack    = ack_q;
  assign bus.io_busy   = (state_q != IDLE);
  assign bus.slv_cs    = cs_q;
  assign bus.slv_rd    = rd_q;
  assign bus.slv_wr    = wr_q;
  assign bus.slv_addr  = addr_q[3:0];
  assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_j1_io_bridge.sv
// Directed plus randomized bench for j1_io_bridge. A behavioural model tracks
// status flags, error address, access count and expected completion latency.
module tb_j1_io_bridge;
  localparam int          NSLV = 4;
  localparam int          TMO  = 15;
  localparam logic [7:0]  BASE = 8'h67;
  localparam logic [15:0] DFLT = 16'h0666;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  j1_io_bridge_if #(.NSLV(NSLV)) bus ();

  j1_io_bridge #(
    .NSLV(NSLV), .PAGE_BASE(BASE), .STAT_PAGE(8'hFF),
    .TMO_CYC(TMO), .DFLT_DATA(DFLT)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_flags;   // {OVR, UNMAP, TMO}
  logic [15:0] m_err;
  logic [15:0] m_stats;
  logic [15:0] m_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_flags = 3'b000;
    m_err   = 16'h0000;
    m_stats = 16'h0000;
    m_din   = 16'h0000;
  endtask

  // One CPU access starting in the current cycle (T). ack_dly is the cycle
  // offset after T at which the addressed slot acks (0 = never); ovr_k is the
  // cycle offset at which an extra read strobe is injected (0 = none).
  task automatic access(input bit wr, input bit rd, input logic [15:0] addr,
                        input logic [15:0] dout, input int ack_dly, input int ovr_k);
    logic [15:0] rdat [NSLV];
    logic [15:0] exp_din;
    logic [15:0] junk;
    logic [NSLV-1:0] noise;
    int page, slot, lat;
    bit tmo, unmap;
    page  = int'(addr[15:8]);
    slot  = -1;
    tmo   = 1'b0;
    unmap = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      rdat[i] = 16'($urandom);
      bus.slv_rdata[16*i +: 16] = rdat[i];
    end

    if (page == 255) begin
      lat = 1;
      if (wr) begin
        exp_din = DFLT;
        if (addr[7:0] == 8'h00) m_flags = m_flags & ~dout[2:0];
`ifdef J1_IO_BRIDGE_STATS_EN
        if (addr[7:0] == 8'h02) m_stats = 16'h0000;
`endif
      end else begin
        case (addr[7:0])
          8'h00:   exp_din = {13'b0, m_flags};
          8'h01:   exp_din = m_err;
          8'h02:   exp_din = m_stats;
          default: exp_din = 16'h0000;
        endcase
      end
    end else if (page >= int'(BASE) && page < int'(BASE) + NSLV) begin
      slot = page - int'(BASE);
      if (ack_dly >= 1 && ack_dly <= TMO) begin
        lat     = ack_dly + 1;
        exp_din = wr ? DFLT : rdat[slot];
      end else begin
        lat     = TMO + 1;
        exp_din = DFLT;
        tmo     = 1'b1;
      end
    end else begin
      lat     = 1;
      exp_din = DFLT;
      unmap   = 1'b1;
    end

    bus.io_wr   = wr;
    bus.io_rd   = rd;
    bus.io_addr = addr;
    bus.io_dout = dout;
    chk("busy_at_T", 32'(bus.io_busy), 32'd0);

    for (int k = 1; k <= lat; k++) begin
      next_cycle();
      bus.io_wr = 1'b0;
      bus.io_rd = (k == ovr_k);
      if (k == ovr_k) begin
        junk = 16'($urandom);
        bus.io_addr = junk;
      end
      noise = NSLV'($urandom);
      if (slot >= 0) noise[slot] = (k == ack_dly);
      bus.slv_ack = noise;

      chk("slv_cs", 32'(bus.slv_cs),
          32'((slot >= 0 && k < lat) ? (1 << slot) : 0));
      chk("slv_rd", 32'(bus.slv_rd), 32'(slot >= 0 && k == 1 && !wr && rd));
      chk("slv_wr", 32'(bus.slv_wr), 32'(slot >= 0 && k == 1 && wr));
      chk("io_busy", 32'(bus.io_busy), 32'd1);
      chk("io_ack", 32'(bus.io_ack), 32'(k == lat));
      if (k < lat) chk("io_din_hold", 32'(bus.io_din), 32'(m_din));
      else         chk("io_din", 32'(bus.io_din), 32'(exp_din));
      if (slot >= 0 && k == 1) begin
        chk("slv_addr", 32'(bus.slv_addr), 32'(addr[3:0]));
        chk("slv_wdata", 32'(bus.slv_wdata), 32'(dout));
      end
    end

    m_din = exp_din;
    if (tmo)   begin m_flags[0] = 1'b1; m_err = addr; end
    if (unmap) begin m_flags[1] = 1'b1; m_err = addr; end
    if (ovr_k >= 1 && ovr_k <= lat) m_flags[2] = 1'b1;
`ifdef J1_IO_BRIDGE_STATS_EN
    if (m_stats != 16'hFFFF) m_stats = m_stats + 16'd1;
`endif

    next_cycle();
    bus.io_rd   = 1'b0;
    bus.slv_ack = '0;
    chk("busy_after", 32'(bus.io_busy), 32'd0);
    chk("ack_after", 32'(bus.io_ack), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cs", 32'(bus.slv_cs), 32'd0);
    chk("rst_rd", 32'(bus.slv_rd), 32'd0);
    chk("rst_wr", 32'(bus.slv_wr), 32'd0);
    chk("rst_ack", 32'(bus.io_ack), 32'd0);
    chk("rst_busy", 32'(bus.io_busy), 32'd0);
    chk("rst_din", 32'(bus.io_din), 32'd0);
    chk("rst_addr", 32'(bus.slv_addr), 32'd0);
    chk("rst_wdata", 32'(bus.slv_wdata), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  pg;
    int kind, dly, ovr;
    bit wr, rd;

    bus.io_rd     = 1'b0;
    bus.io_wr     = 1'b0;
    bus.io_addr   = 16'h0000;
    bus.io_dout   = 16'h0000;
    bus.slv_rdata = '0;
    bus.slv_ack   = '0;
    model_reset();

    rst = 1'b1;
    next_cycle();
    next_cycle();
    chk_reset_outputs();
    rst = 1'b0;
    next_cycle();

    // Slot 1 read, ack two cycles in
    access(1'b0, 1'b1, 16'h6803, 16'h0000, 2, 0);
    // Slot 3 write that never acks, then status readback
    access(1'b1, 1'b0, 16'h6A01, 16'hBEEF, 0, 0);
    access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);
    access(1'b0, 1'b1, 16'hFF01, 16'h0000, 0, 0);
    // Unmapped read, W1C of UNMAP only
    access(1'b0, 1'b1, 16'h5000, 16'h0000, 0, 0);
    access(1'b1, 1'b0, 16'hFF00, 16'h0002, 0, 0);
    access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);
    // Overlapping request during a slot 0 transaction
    access(1'b0, 1'b1, 16'h6700, 16'h0000, 3, 1);
    access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);
    access(1'b1, 1'b0, 16'hFF00, 16'h0007, 0, 0);
    access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);
    // Ack on the last counted cycle succeeds, one later times out
    access(1'b0, 1'b1, 16'h6710, 16'h0000, TMO, 0);
    access(1'b0, 1'b1, 16'h6720, 16'h0000, TMO + 1, 0);
    // Read and write together: write only
    access(1'b1, 1'b1, 16'h6802, 16'hAAAA, 1, 0);
    // Overlap during the completion cycle
    access(1'b0, 1'b1, 16'h1234, 16'h0000, 0, 1);
    access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);
    access(1'b0, 1'b1, 16'hFF05, 16'h0000, 0, 0);

    // Reset in the middle of a stalled slot 2 read
    bus.io_rd   = 1'b1;
    bus.io_addr = 16'h6900;
    next_cycle();
    bus.io_rd   = 1'b0;
    chk("stall_cs", 32'(bus.slv_cs), 32'h4);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    model_reset();
    chk_reset_outputs();
    access(1'b0, 1'b1, 16'h6700, 16'h0000, 1, 0);
    access(1'b0, 1'b1, 16'hFF00, 16'h0000, 0, 0);
    access(1'b1, 1'b0, 16'h6801, 16'h5555, 4, 0);
    access(1'b0, 1'b1, 16'hFF02, 16'h0000, 0, 0);
    // Counter restart by a write to offset 2
    access(1'b1, 1'b0, 16'hFF02, 16'h0000, 0, 0);
    access(1'b0, 1'b1, 16'hFF02, 16'h0000, 0, 0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      r    = $urandom;
      wr   = 1'($urandom_range(0, 1));
      rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      dly  = $urandom_range(0, TMO + 2);
      ovr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (kind <= 4) begin
        pg = BASE + 8'($urandom_range(0, NSLV - 1));
        access(wr, rd, {pg, r[7:0]}, r[31:16], dly, ovr);
      end else if (kind <= 6) begin
        pg = r[15:8];
        while ((pg >= BASE && pg < BASE + 8'(NSLV)) || pg == 8'hFF) pg = pg + 8'd13;
        access(wr, rd, {pg, r[7:0]}, r[31:16], 0, ovr);
      end else if (kind <= 8) begin
        access(1'b0, 1'b1, {8'hFF, 8'($urandom_range(0, 3))}, 16'h0000, 0, ovr);
      end else begin
        access(1'b1, 1'b0, {8'hFF, (r[0] ? 8'h02 : 8'h00)}, r[31:16], 0, ovr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
